// File: rtl/fmap_pkg.sv
// -----------------------------------------------------------------------------
// fmap_pkg
// Shared types and size helpers for the feature-map stream reader.
//   state_t           : controller states (IDLE/FILL/FULL/READ/DONE)
//   fmap_depth()      : words stored for one feature map
//   fmap_width()      : bits needed to index 0..n-1 (never less than 1)
//   fmap_padded_side(): side length once the zero border is added
// Build option: FMAP_ZERO_PAD_EN (the padded side is used only when defined).
// -----------------------------------------------------------------------------
package fmap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_FULL,
      ST_READ,
      ST_DONE
   } state_t;

   // Border thickness consumed by a 3x3 same-padding convolution.
   localparam int PAD_BORDER = 1;

   function automatic int fmap_depth(input int image_width, input int channels);
      return image_width * image_width * channels;
   endfunction

   function automatic int fmap_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int fmap_padded_side(input int image_width);
      return image_width + 2 * PAD_BORDER;
   endfunction

endpackage

// File: rtl/fmap_ram.sv
// -----------------------------------------------------------------------------
// fmap_ram
// Simple dual-port RAM: one write port, one registered read port.
// Written to map onto a block RAM (no reset, synchronous read).
//   clk        : clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read strobe; o_rd_data updates on the following edge
//   i_rd_addr  : read address
//   o_rd_data  : registered read data
// -----------------------------------------------------------------------------
module fmap_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 3136,
   parameter int ADDR_W     = 12
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_W-1:0]     i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_W-1:0]     i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   // NOTE: the array and its read register carry no reset; a reset here would
   // stop the tools from mapping the storage onto block RAM.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fmap_stream_reader.sv
// -----------------------------------------------------------------------------
// fmap_stream_reader
// Captures one feature map written channel-major (row, column) by a conv
// block, then replays it on request as a valid/ready stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_valid    : producer write strobe, i_data : producer pixel
//   o_full     : a complete map is held
//   o_overflow : sticky, a write arrived while not accepting
//   i_start    : pulse in FULL to begin replay
//   i_ready    : consumer accepts a pixel this cycle
//   o_valid, o_data, o_last : replay stream, o_last on the final pixel
//   o_done     : one-cycle pulse after the final transfer
// Build option: FMAP_ZERO_PAD_EN adds a 1-pixel zero border to every channel
// on replay; the write side is unchanged.
// -----------------------------------------------------------------------------
module fmap_stream_reader
   import fmap_pkg::*;
#(
   parameter int DATA_WIDTH        = 32,
   parameter int IMAGE_WIDTH       = 7,
   parameter int NUMBER_OF_CHANNEL = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_full,
   output logic                  o_overflow,
   input  logic                  i_start,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   output logic                  o_done
);

   localparam int DEPTH  = fmap_depth(IMAGE_WIDTH, NUMBER_OF_CHANNEL);
   localparam int ADDR_W = fmap_width(DEPTH);
`ifdef FMAP_ZERO_PAD_EN
   localparam int SIDE   = fmap_padded_side(IMAGE_WIDTH);
`else
   localparam int SIDE   = IMAGE_WIDTH;
`endif
   localparam int POS_W  = fmap_width(SIDE);
   localparam int CH_W   = fmap_width(NUMBER_OF_CHANNEL);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(SIDE - 1);
   localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUMBER_OF_CHANNEL - 1);

   state_t                r_state, w_next_state;
   logic [ADDR_W-1:0]     r_wr_addr, r_rd_addr;
   logic [CH_W-1:0]       r_ch;
   logic [POS_W-1:0]      r_row, r_col;
   logic                  r_issue_done, r_overflow;
   // Read pipeline: RAM output (pend) -> skid -> output register.
   logic                  r_pend, r_pend_zero, r_pend_last;
   logic                  r_skid_vld, r_skid_last;
   logic [DATA_WIDTH-1:0] r_skid_data;
   logic                  r_out_vld, r_out_last;
   logic [DATA_WIDTH-1:0] r_out_data;

   logic                  w_accept, w_wr_en, w_xfer, w_issue, w_rd_en;
   logic                  w_border, w_last_pos;
   logic [1:0]            w_occ;
   logic [DATA_WIDTH-1:0] w_ram_q, w_pend_data;

   fmap_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_addr),
      .i_wr_data (i_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_rd_addr),
      .o_rd_data (w_ram_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_wr_en      = 1'b0;
      w_accept     = (r_state == ST_IDLE) || (r_state == ST_FILL);
      w_xfer       = r_out_vld && i_ready;
`ifdef FMAP_ZERO_PAD_EN
      w_border     = (r_row == '0) || (r_row == LAST_POS) ||
                     (r_col == '0) || (r_col == LAST_POS);
`else
      w_border     = 1'b0;
`endif
      w_last_pos   = (r_ch == LAST_CH) && (r_row == LAST_POS) && (r_col == LAST_POS);
      // Words that will sit in out/skid after this edge. A new read is issued
      // only if a slot is still free for it next cycle, whatever i_ready does.
      w_occ        = {1'b0, r_out_vld & ~i_ready} + {1'b0, r_skid_vld} + {1'b0, r_pend};
      w_issue      = (r_state == ST_READ) && !r_issue_done && (w_occ <= 2'd1);
      w_rd_en      = w_issue && !w_border;
      unique case (r_state)
         ST_IDLE, ST_FILL: begin
            if (i_valid) begin
               w_wr_en      = 1'b1;
               w_next_state = (r_wr_addr == LAST_ADDR) ? ST_FULL : ST_FILL;
            end
         end
         ST_FULL: if (i_start) w_next_state = ST_READ;
         ST_READ: if (w_xfer && r_out_last) w_next_state = ST_DONE;
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_pend_data = r_pend_zero ? '0 : w_ram_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_addr    <= '0;
         r_rd_addr    <= '0;
         r_ch         <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_issue_done <= 1'b0;
         r_overflow   <= 1'b0;
         r_pend       <= 1'b0;
         r_pend_zero  <= 1'b0;
         r_pend_last  <= 1'b0;
         r_skid_vld   <= 1'b0;
         r_skid_last  <= 1'b0;
         r_skid_data  <= '0;
         r_out_vld    <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_data   <= '0;
      end else begin
         if (w_wr_en) r_wr_addr <= (r_wr_addr == LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
         if (i_valid && !w_accept) r_overflow <= 1'b1;

         // Read walk: col fastest, then row, then channel.
         if (r_state != ST_READ) begin
            r_ch         <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_rd_addr    <= '0;
            r_issue_done <= 1'b0;
         end else if (w_issue) begin
            if (w_rd_en)    r_rd_addr    <= r_rd_addr + 1'b1;
            if (w_last_pos) r_issue_done <= 1'b1;
            if (r_col == LAST_POS) begin
               r_col <= '0;
               if (r_row == LAST_POS) begin
                  r_row <= '0;
                  r_ch  <= (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
               end else begin
                  r_row <= r_row + 1'b1;
               end
            end else begin
               r_col <= r_col + 1'b1;
            end
         end

         r_pend      <= w_issue;
         r_pend_zero <= w_issue && w_border;
         r_pend_last <= w_issue && w_last_pos;

         // Output register refills from the skid first (older word), then
         // from the RAM; a word arriving during a stall parks in the skid.
         if (!r_out_vld || i_ready) begin
            if (r_skid_vld) begin
               r_out_vld   <= 1'b1;
               r_out_data  <= r_skid_data;
               r_out_last  <= r_skid_last;
               r_skid_vld  <= r_pend;
               r_skid_data <= w_pend_data;
               r_skid_last <= r_pend_last;
            end else begin
               r_out_vld  <= r_pend;
               r_out_last <= r_pend && r_pend_last;
               if (r_pend) r_out_data <= w_pend_data;
            end
         end else if (r_pend) begin
            r_skid_vld  <= 1'b1;
            r_skid_data <= w_pend_data;
            r_skid_last <= r_pend_last;
         end
      end
   end

   assign o_full     = (r_state == ST_FULL) || (r_state == ST_READ);
   assign o_overflow = r_overflow;
   assign o_valid    = r_out_vld;
   assign o_data     = r_out_data;
   assign o_last     = r_out_last;
   assign o_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_fmap_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fmap_stream_reader
// Self-checking bench for fmap_stream_reader with a 3x3x2 map. The reference
// model stores the map as a [channel][row][col] array and derives the expected
// replay sequence (padded or not, following FMAP_ZERO_PAD_EN) with nested loops.
// -----------------------------------------------------------------------------
module tb_fmap_stream_reader;

   localparam int DW    = 32;
   localparam int IW    = 3;
   localparam int NC    = 2;
   localparam int DEPTH = IW * IW * NC;
`ifdef FMAP_ZERO_PAD_EN
   localparam int SIDE  = IW + 2;
   localparam bit PAD   = 1'b1;
`else
   localparam int SIDE  = IW;
   localparam bit PAD   = 1'b0;
`endif
   localparam int NOUT  = NC * SIDE * SIDE;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          i_valid = 1'b0;
   logic [DW-1:0] i_data  = '0;
   logic          i_start = 1'b0;
   logic          i_ready = 1'b0;
   logic          o_full, o_overflow, o_valid, o_last, o_done;
   logic [DW-1:0] o_data;

   fmap_stream_reader #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .NUMBER_OF_CHANNEL(NC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .o_full     (o_full),
      .o_overflow (o_overflow),
      .i_start    (i_start),
      .i_ready    (i_ready),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_last     (o_last),
      .o_done     (o_done)
   );

   always #5 clk = ~clk;

   int            n_err = 0;
   int            n_chk = 0;
   logic [DW-1:0] model_pix [NC][IW][IW];
   logic [DW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void build_expected();
      exp_q.delete();
      for (int ch = 0; ch < NC; ch++)
         for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++) begin
               if (!PAD)
                  exp_q.push_back(model_pix[ch][r][c]);
               else if (r == 0 || c == 0 || r == SIDE - 1 || c == SIDE - 1)
                  exp_q.push_back('0);
               else
                  exp_q.push_back(model_pix[ch][r-1][c-1]);
            end
   endfunction

   // mode 0: address+1, mode 1: address+101, otherwise random words.
   task automatic fill(input int mode, input bit gaps, input bit start_probe);
      logic [DW-1:0] d;
      for (int a = 0; a < DEPTH; a++) begin
         if (gaps)
            while ($urandom_range(3) == 0) begin
               i_valid = 1'b0;
               tick();
            end
         case (mode)
            0:       d = DW'(a + 1);
            1:       d = DW'(a + 101);
            default: d = $urandom;
         endcase
         if (a == DEPTH - 1) check("full_before_last", o_full, 0);
         if (start_probe && (a == 10 || a == DEPTH - 1)) i_start = 1'b1;
         i_valid = 1'b1;
         i_data  = d;
         model_pix[a / (IW * IW)][(a / IW) % IW][a % IW] = d;
         tick();
         i_valid = 1'b0;
         i_start = 1'b0;
      end
      check("full_after_last", o_full, 1);
      if (start_probe)
         for (int k = 0; k < 5; k++) begin
            check("start_ignored_vld", o_valid, 0);
            tick();
         end
   endtask

   task automatic extra_writes(input int n);
      for (int k = 0; k < n; k++) begin
         i_valid = 1'b1;
         i_data  = $urandom;
         tick();
         i_valid = 1'b0;
         check("overflow_set", o_overflow, 1);
      end
      check("full_after_extra", o_full, 1);
   endtask

   // rmode 0: ready held high, 1: ready 1,0,0,1 repeating, 2: random ready.
   // abort_at >= 0 pulls reset while that pixel index is on the output.
   task automatic replay(input int rmode, input int abort_at);
      int            idx     = 0;
      int            cyc     = 0;
      int            budget  = 0;
      bit            stalled = 1'b0;
      logic [DW-1:0] held_d  = '0;
      logic          held_l  = 1'b0;
      build_expected();
      i_ready = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("lat_cycle0_vld", o_valid, 0);
      tick();
      check("lat_cycle1_vld", o_valid, 0);
      tick();
      check("lat_cycle2_vld", o_valid, 1);
      while (idx < NOUT) begin
         if (budget++ > 40 * NOUT) begin
            check("replay_timeout_count", DW'(idx), DW'(NOUT));
            return;
         end
         if (stalled) begin
            check("stall_vld", o_valid, 1);
            check("stall_data", o_data, held_d);
            check("stall_last", o_last, held_l);
         end
         if (rmode == 0) check("no_bubble_vld", o_valid, 1);
         if (!o_valid) check("last_without_vld", o_last, 0);
         if (o_valid && idx == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_vld", o_valid, 0);
            check("abort_data", o_data, 0);
            check("abort_last", o_last, 0);
            check("abort_full", o_full, 0);
            check("abort_done", o_done, 0);
            i_ready = 1'b0;
            return;
         end
         case (rmode)
            0:       i_ready = 1'b1;
            1:       i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: i_ready = 1'($urandom_range(1));
         endcase
         cyc++;
         if (o_valid && i_ready) begin
            check($sformatf("pix%0d_data", idx), o_data, exp_q[idx]);
            check($sformatf("pix%0d_last", idx), o_last, (idx == NOUT - 1));
            idx++;
            stalled = 1'b0;
         end else if (o_valid) begin
            stalled = 1'b1;
            held_d  = o_data;
            held_l  = o_last;
         end else begin
            stalled = 1'b0;
         end
         tick();
      end
      i_ready = 1'b0;
      check("done_pulse", o_done, 1);
      check("done_full", o_full, 0);
      check("done_vld", o_valid, 0);
      tick();
      check("done_end", o_done, 0);
      check("idle_full", o_full, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #3;
      check("rst_vld", o_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_last", o_last, 0);
      check("rst_done", o_done, 0);
      check("rst_full", o_full, 0);
      check("rst_overflow", o_overflow, 0);
      do_reset();

      // Plain fill and back-to-back replay.
      fill(0, 1'b0, 1'b0);
      check("no_overflow", o_overflow, 0);
      replay(0, -1);

      // Same data, ready pattern 1,0,0,1.
      fill(0, 1'b1, 1'b0);
      replay(1, -1);

      // Extra writes in FULL are dropped and flag overflow.
      fill(2, 1'b1, 1'b0);
      extra_writes(3);
      replay(2, -1);
      check("overflow_sticky", o_overflow, 1);
      do_reset();
      check("overflow_cleared", o_overflow, 0);

      // i_start during FILL and with the final write is ignored.
      fill(0, 1'b0, 1'b1);
      replay(0, -1);

      // Reset at the 7th output pixel, then refill with 101.. and replay.
      fill(0, 1'b0, 1'b0);
      replay(0, 6);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_abort_full", o_full, 0);
      fill(1, 1'b0, 1'b0);
      replay(2, -1);

      // Random data and random back-pressure.
      for (int k = 0; k < 4; k++) begin
         fill(2, 1'b1, 1'b0);
         replay(2, -1);
      end
      check("final_overflow", o_overflow, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
